// File: rtl/cpu_ocimem_arbiter.sv
// Round-robin arbiter between the buffered JTAG monitor port and the Avalon debug slave for the debug RAM.
// One RAM access per grant: IDLE -> ACC -> (RD) -> IDLE. JTAG commands are never stalled; excess ones are dropped.
module cpu_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic              ram_en,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {IDLE, ACC, RD} state_t;

  state_t            state;
  logic              own_avs;
  logic              last_avs;
  logic              cmd_wr;
  logic [ADDR_W-1:0] addr;
  logic              jbuf_vld;
  logic              jbuf_wr;
  logic [31:0]       jbuf_dat;

  logic avs_req;
  logic pick_avs;
  logic jtag_busy;
  logic unused_jdo;

  assign avs_req    = avs_read | avs_write;
  // On a tie the requester that was not granted last time wins.
  assign pick_avs   = avs_req & (~jbuf_vld | ~last_avs);
  assign jtag_busy  = jbuf_vld | ((state != IDLE) & ~own_avs);
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

  assign avs_waitrequest = ~(((state == ACC) & own_avs & cmd_wr) | ((state == RD) & own_avs));
  assign avs_readdata    = (state == RD) ? ram_rdata : 32'd0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      own_avs       <= 1'b0;
      last_avs      <= 1'b1;
      cmd_wr        <= 1'b0;
      addr          <= '0;
      jbuf_vld      <= 1'b0;
      jbuf_wr       <= 1'b0;
      jbuf_dat      <= 32'd0;
      MonDReg       <= 32'd0;
      monitor_ready <= 1'b0;
      jtag_overrun  <= 1'b0;
      ram_en        <= 1'b0;
      ram_wr        <= 1'b0;
      ram_addr      <= '0;
      ram_wdata     <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (jbuf_vld || avs_req) begin
            state    <= ACC;
            ram_en   <= 1'b1;
            own_avs  <= pick_avs;
            last_avs <= pick_avs;
            if (pick_avs) begin
              cmd_wr    <= avs_write;
              ram_wr    <= avs_write & avs_debugaccess;
              ram_addr  <= avs_address;
              ram_wdata <= avs_writedata;
            end else begin
              cmd_wr    <= jbuf_wr;
              ram_wr    <= jbuf_wr;
              ram_addr  <= addr;
              ram_wdata <= jbuf_dat;
            end
          end
        end
        ACC: begin
          ram_en <= 1'b0;
          ram_wr <= 1'b0;
          state  <= cmd_wr ? IDLE : RD;
          if (!own_avs && cmd_wr) begin
            addr          <= addr + 1'b1;
            jbuf_vld      <= 1'b0;
            monitor_ready <= 1'b1;
          end
        end
        RD: begin
          state <= IDLE;
          if (!own_avs) begin
            MonDReg       <= ram_rdata;
            addr          <= addr + 1'b1;
            jbuf_vld      <= 1'b0;
            monitor_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // Pulses come after completion so an address load overrides the auto-increment.
      if (take_action_ocimem_a) begin
        addr          <= jdo[10 +: ADDR_W];
        monitor_ready <= 1'b0;
        jtag_overrun  <= 1'b0;
        if (jdo[35]) begin
          if (jtag_busy) begin
            jtag_overrun <= 1'b1;
          end else begin
            jbuf_vld <= 1'b1;
            jbuf_wr  <= 1'b0;
          end
        end
      end else if (take_action_ocimem_b) begin
        monitor_ready <= 1'b0;
        if (jtag_busy) begin
          jtag_overrun <= 1'b1;
        end else begin
          jbuf_vld <= 1'b1;
          jbuf_wr  <= 1'b1;
          jbuf_dat <= jdo[34:3];
        end
      end else if (take_no_action_ocimem_a) begin
        monitor_ready <= 1'b0;
        if (jtag_busy) begin
          jtag_overrun <= 1'b1;
        end else begin
          jbuf_vld <= 1'b1;
          jbuf_wr  <= 1'b0;
        end
      end
    end
  end

endmodule
